// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int          FETCH_ADDR_W      = 32;
  localparam int          FETCH_DATA_W      = 32;
  localparam int          FQ_DEPTH_DEFAULT  = 8;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  function automatic int fq_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  localparam int FQ_PTR_W = fq_ptr_w(FQ_DEPTH_DEFAULT);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_DATA_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0] addr;
    logic                    pred_taken;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-in / two-out circular buffer holding fetched instructions for decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  FQ_DEPTH = FQ_DEPTH_DEFAULT,
  parameter type entry_t  = fetch_entry_t
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [1:0]                  push_cnt,
  input  entry_t                      push_entry_0,
  input  entry_t                      push_entry_1,
  input  logic [1:0]                  pop_cnt,
  output logic [fq_ptr_w(FQ_DEPTH):0] count,
  output entry_t                      head_entry_0,
  output entry_t                      head_entry_1
);

  localparam int PTR_W = fq_ptr_w(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t           mem_q [FQ_DEPTH];
  entry_t           mem_d [FQ_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, head_p1;
  logic [PTR_W-1:0] tail_q, tail_d, tail_p1;
  logic [CNT_W-1:0] count_q, count_d;

  assign head_p1 = head_q + PTR_W'(1);
  assign tail_p1 = tail_q + PTR_W'(1);

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_cnt != 2'd0) mem_d[tail_q]  = push_entry_0;
      if (push_cnt == 2'd2) mem_d[tail_p1] = push_entry_1;
      tail_d  = tail_q + PTR_W'(push_cnt);
      head_d  = head_q + PTR_W'(pop_cnt);
      count_d = count_q + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count        = count_q;
  assign head_entry_0 = mem_q[head_q];
  assign head_entry_1 = mem_q[head_p1];

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch initiator: PC, two-wide request, push control and fetch queue.
//   state   | meaning
//   ST_RUN  | issuing requests, pushing returned pairs when the queue has room
//   ST_HALT | ran off the end of memory; waits for a redirect
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = FETCH_ADDR_W,
  parameter int                    DATA_WIDTH = FETCH_DATA_W,
  parameter int                    FQ_DEPTH   = FQ_DEPTH_DEFAULT,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] bp_pc,
  input  logic                  bp_taken,
  input  logic [ADDR_WIDTH-1:0] bp_target,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_predict_taken,
  output logic [ADDR_WIDTH-1:0] mem_predict_target,
  input  logic [DATA_WIDTH-1:0] mem_instr_0,
  input  logic [DATA_WIDTH-1:0] mem_instr_1,
  input  logic [1:0]            mem_valid,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [1:0]            fq_valid,
  output logic [DATA_WIDTH-1:0] fq_instr_0,
  output logic [DATA_WIDTH-1:0] fq_instr_1,
  output logic [ADDR_WIDTH-1:0] fq_addr_0,
  output logic [ADDR_WIDTH-1:0] fq_addr_1,
  output logic                  fq_pred_taken_0,
  output logic                  fq_pred_taken_1,
  input  logic [1:0]            fq_pop,
  output logic                  halted
);

  localparam int CNT_W = fq_ptr_w(FQ_DEPTH) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  pred_taken;
  } entry_t;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]      count;
  logic                  can_push;
  logic                  flush;
  logic [1:0]            push_cnt;
  logic [1:0]            pop_cnt;
  entry_t                push_entry_0, push_entry_1;
  entry_t                head_entry_0, head_entry_1;
  logic                  unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign bp_pc              = pc_q;
  assign mem_addr           = pc_q;
  assign mem_predict_taken  = bp_taken;
  assign mem_predict_target = bp_taken ? bp_target : pc_q + ADDR_WIDTH'(4);

  // Room for a full pair is judged on occupancy before this cycle's pops.
  assign can_push = (state_q == ST_RUN) && !redirect_valid
                    && (count <= CNT_W'(FQ_DEPTH - 2));

  assign push_entry_0 = '{instr: mem_instr_0, addr: pc_q, pred_taken: bp_taken};
  assign push_entry_1 = '{instr: mem_instr_1, addr: mem_predict_target, pred_taken: 1'b0};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    push_cnt = 2'd0;
    flush    = 1'b0;
    if (redirect_valid) begin
      flush   = 1'b1;
      state_d = ST_RUN;
      pc_d    = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    end else if (can_push) begin
      if (!mem_valid[0]) begin
        state_d = ST_HALT;
      end else if (mem_valid[1]) begin
        push_cnt = 2'd2;
        pc_d     = mem_predict_target + ADDR_WIDTH'(4);
      end else begin
        push_cnt = 2'd1;
        pc_d     = mem_predict_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign fq_valid = {count >= CNT_W'(2), count >= CNT_W'(1)};

  always_comb begin
    pop_cnt = 2'd0;
    if (fq_pop == 2'b11 && fq_valid[1])  pop_cnt = 2'd2;
    else if (fq_pop[0] && fq_valid[0])   pop_cnt = 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (fq_pop != 2'b10);
      assert (!(fq_pop[0] && !fq_valid[0]) && !(fq_pop[1] && !fq_valid[1]));
    end
  end

  fetch_queue #(
    .FQ_DEPTH (FQ_DEPTH),
    .entry_t  (entry_t)
  ) u_fetch_queue (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .push_cnt     (push_cnt),
    .push_entry_0 (push_entry_0),
    .push_entry_1 (push_entry_1),
    .pop_cnt      (pop_cnt),
    .count        (count),
    .head_entry_0 (head_entry_0),
    .head_entry_1 (head_entry_1)
  );

  assign fq_instr_0      = head_entry_0.instr;
  assign fq_instr_1      = head_entry_1.instr;
  assign fq_addr_0       = head_entry_0.addr;
  assign fq_addr_1       = head_entry_1.addr;
  assign fq_pred_taken_0 = head_entry_0.pred_taken;
  assign fq_pred_taken_1 = head_entry_1.pred_taken;

  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller against a 4 KiB combinational instruction memory.
module tb_fetch_controller;

  localparam int MEM_SIZE = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bp_pc;
  logic        bp_taken;
  logic [31:0] bp_target;
  logic [31:0] mem_addr;
  logic        mem_predict_taken;
  logic [31:0] mem_predict_target;
  logic [31:0] mem_instr_0, mem_instr_1;
  logic [1:0]  mem_valid;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [1:0]  fq_valid;
  logic [31:0] fq_instr_0, fq_instr_1;
  logic [31:0] fq_addr_0, fq_addr_1;
  logic        fq_pred_taken_0, fq_pred_taken_1;
  logic [1:0]  fq_pop = 2'b00;
  logic        halted;
  logic        bp_en = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return 32'h0000_0013 ^ (a << 8);
  endfunction

  assign bp_taken    = bp_en && (bp_pc == 32'h10);
  assign bp_target   = 32'h100;
  assign mem_instr_0 = instr_at(mem_addr);
  assign mem_instr_1 = instr_at(mem_predict_target);
  assign mem_valid   = {mem_predict_target < MEM_SIZE, mem_addr < MEM_SIZE};

  fetch_controller dut (
    .clk                (clk),
    .rst                (rst),
    .bp_pc              (bp_pc),
    .bp_taken           (bp_taken),
    .bp_target          (bp_target),
    .mem_addr           (mem_addr),
    .mem_predict_taken  (mem_predict_taken),
    .mem_predict_target (mem_predict_target),
    .mem_instr_0        (mem_instr_0),
    .mem_instr_1        (mem_instr_1),
    .mem_valid          (mem_valid),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .fq_valid           (fq_valid),
    .fq_instr_0         (fq_instr_0),
    .fq_instr_1         (fq_instr_1),
    .fq_addr_0          (fq_addr_0),
    .fq_addr_1          (fq_addr_1),
    .fq_pred_taken_0    (fq_pred_taken_0),
    .fq_pred_taken_1    (fq_pred_taken_1),
    .fq_pop             (fq_pop),
    .halted             (halted)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_head;

    step();
    step();
    rst = 1'b0;
    chk("rst_valid", 64'(fq_valid), 64'(2'b00));
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_pc", 64'(mem_addr), 64'h0);
    chk("rst_tgt", 64'(mem_predict_target), 64'h4);

    // fill from reset, no pops
    step();
    chk("fill_valid", 64'(fq_valid), 64'(2'b11));
    chk("fill_addr0", 64'(fq_addr_0), 64'h0);
    chk("fill_addr1", 64'(fq_addr_1), 64'h4);
    chk("fill_instr0", 64'(fq_instr_0), 64'(instr_at(32'h0)));
    chk("fill_pc1", 64'(mem_addr), 64'h8);
    step();
    chk("fill_pc2", 64'(mem_addr), 64'h10);
    step();
    chk("fill_pc3", 64'(mem_addr), 64'h18);
    step();
    chk("fill_pc4", 64'(mem_addr), 64'h20);
    step();
    step();
    step();
    chk("full_pc", 64'(mem_addr), 64'h20);
    chk("full_head", 64'(fq_addr_0), 64'h0);

    // steady two-in/two-out across pointer wrap
    fq_pop = 2'b11;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_head = 32'(k * 8);
      chk("stream_addr0", 64'(fq_addr_0), 64'(exp_head));
      chk("stream_addr1", 64'(fq_addr_1), 64'(exp_head + 32'h4));
      chk("stream_instr1", 64'(fq_instr_1), 64'(instr_at(exp_head + 32'h4)));
    end
    fq_pop = 2'b00;
    step();
    chk("stream_pc", 64'(mem_addr), 64'h80);

    // predicted-taken branch at 0x10
    bp_en          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    step();
    redirect_valid = 1'b0;
    chk("bp_flush_valid", 64'(fq_valid), 64'(2'b00));
    chk("bp_pc", 64'(mem_addr), 64'h10);
    chk("bp_req_taken", 64'(mem_predict_taken), 64'd1);
    chk("bp_req_tgt", 64'(mem_predict_target), 64'h100);
    step();
    chk("bp_valid", 64'(fq_valid), 64'(2'b11));
    chk("bp_addr0", 64'(fq_addr_0), 64'h10);
    chk("bp_pt0", 64'(fq_pred_taken_0), 64'd1);
    chk("bp_addr1", 64'(fq_addr_1), 64'h100);
    chk("bp_pt1", 64'(fq_pred_taken_1), 64'd0);
    chk("bp_instr1", 64'(fq_instr_1), 64'(instr_at(32'h100)));
    chk("bp_next_pc", 64'(mem_addr), 64'h104);
    bp_en = 1'b0;

    // build count=5 with a single pop, then redirect with pop=11
    step();
    fq_pop = 2'b01;
    step();
    fq_pop = 2'b00;
    chk("pop1_addr0", 64'(fq_addr_0), 64'h100);
    chk("pop1_addr1", 64'(fq_addr_1), 64'h104);
    chk("pop1_pc", 64'(mem_addr), 64'h114);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    fq_pop         = 2'b11;
    step();
    redirect_valid = 1'b0;
    fq_pop         = 2'b00;
    chk("redir_valid", 64'(fq_valid), 64'(2'b00));
    chk("redir_pc", 64'(mem_addr), 64'h40);
    step();
    chk("redir_valid2", 64'(fq_valid), 64'(2'b11));
    chk("redir_addr0", 64'(fq_addr_0), 64'h40);
    chk("redir_addr1", 64'(fq_addr_1), 64'h44);
    chk("redir_instr1", 64'(fq_instr_1), 64'(instr_at(32'h44)));

    // end of memory
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFC;
    step();
    redirect_valid = 1'b0;
    chk("eom_memvalid", 64'(mem_valid), 64'(2'b01));
    step();
    chk("eom_valid", 64'(fq_valid), 64'(2'b01));
    chk("eom_addr0", 64'(fq_addr_0), 64'hFFC);
    chk("eom_halted0", 64'(halted), 64'd0);
    chk("eom_pc", 64'(mem_addr), 64'h1000);
    step();
    chk("eom_halted1", 64'(halted), 64'd1);
    chk("eom_nopush", 64'(fq_valid), 64'(2'b01));
    step();
    chk("eom_halted2", 64'(halted), 64'd1);
    chk("eom_pc_hold", 64'(mem_addr), 64'h1000);
    chk("eom_nopush2", 64'(fq_valid), 64'(2'b01));
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    step();
    redirect_valid = 1'b0;
    chk("resume_halted", 64'(halted), 64'd0);
    chk("resume_valid", 64'(fq_valid), 64'(2'b00));
    chk("resume_pc", 64'(mem_addr), 64'h0);
    step();
    chk("resume_valid2", 64'(fq_valid), 64'(2'b11));
    chk("resume_addr0", 64'(fq_addr_0), 64'h0);

    // reset with queue half full
    step();
    chk("mid_pc", 64'(mem_addr), 64'h10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(fq_valid), 64'(2'b00));
    chk("mid_rst_halted", 64'(halted), 64'd0);
    chk("mid_rst_pc", 64'(mem_addr), 64'h0);
    step();
    chk("mid_rst_refill", 64'(fq_valid), 64'(2'b11));
    chk("mid_rst_addr1", 64'(fq_addr_1), 64'h4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
